// File: rtl/ulpb_rx_buffer.sv
// Receive buffer between a ULPB bus node and a consumer: a four-phase REQ/ACK write side
// and a first-word-fall-through valid/ready read side. Optional drop-on-full mode: ULPB_RXBUF_DROP_EN.
module ulpb_rx_buffer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [ADDR_WIDTH-1:0]    RX_ADDR,
    input  logic [DATA_WIDTH-1:0]    RX_DATA,
    input  logic                     RX_REQ,
    input  logic                     RX_PEND,
    output logic                     RX_ACK,
    output logic [ADDR_WIDTH-1:0]    OUT_ADDR,
    output logic [DATA_WIDTH-1:0]    OUT_DATA,
    output logic                     OUT_LAST,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    input  logic                     OVF_CLR,
    output logic                     ACK_STATE
);

    // Write side: RX_REQ raises a word; RX_ACK rises the cycle after it is taken (or dropped)
    // and stays high until RX_REQ falls. Read side: the head entry moves on OUT_VALID & OUT_READY.
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic {
        ACK_IDLE = 1'b0,
        ACK_WAIT = 1'b1
    } ack_state_t;

    ack_state_t        state, state_nxt;
    logic [EW-1:0]     mem [DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr;
    logic              full, empty, wr_en, rd_en;

    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign rd_en = ~empty & OUT_READY;

`ifdef ULPB_RXBUF_DROP_EN
    logic drop;
`endif

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
`ifdef ULPB_RXBUF_DROP_EN
        drop      = 1'b0;
`endif
        case (state)
            ACK_IDLE: begin
                if (RX_REQ) begin
                    if (!full) begin
                        wr_en     = 1'b1;
                        state_nxt = ACK_WAIT;
                    end
`ifdef ULPB_RXBUF_DROP_EN
                    else begin
                        drop      = 1'b1;
                        state_nxt = ACK_WAIT;
                    end
`endif
                end
            end
            ACK_WAIT: begin
                if (!RX_REQ) state_nxt = ACK_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= ACK_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is intentionally not reset; OUT_VALID masks stale contents.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr[PW-1:0]] <= {~RX_PEND, RX_ADDR, RX_DATA};
    end

    assign {OUT_LAST, OUT_ADDR, OUT_DATA} = mem[rd_ptr[PW-1:0]];
    assign OUT_VALID = ~empty;
    assign COUNT     = wr_ptr - rd_ptr;
    assign RX_ACK    = (state == ACK_WAIT);
    assign ACK_STATE = state;

`ifdef ULPB_RXBUF_DROP_EN
    // A drop in the same cycle as a clear wins, so no overflow event is lost.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)        OVERFLOW <= 1'b0;
        else if (drop)    OVERFLOW <= 1'b1;
        else if (OVF_CLR) OVERFLOW <= 1'b0;
    end
`else
    logic ovf_clr_unused;
    assign ovf_clr_unused = OVF_CLR;
    assign OVERFLOW       = 1'b0;
`endif

endmodule

// File: tb/tb_ulpb_rx_buffer.sv
// Self-checking bench for ulpb_rx_buffer: directed scenarios plus a randomized run
// against a queue-based reference model of the buffer and handshake.
module tb_ulpb_rx_buffer;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 1 + AW + DW;

    logic          clk;
    logic          reset;
    logic [AW-1:0] rx_addr;
    logic [DW-1:0] rx_data;
    logic          rx_req, rx_pend, rx_ack;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last, out_valid, out_ready;
    logic [CW-1:0] count;
    logic          overflow, ovf_clr, ack_state;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];

    ulpb_rx_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK(clk), .RESET(reset),
        .RX_ADDR(rx_addr), .RX_DATA(rx_data), .RX_REQ(rx_req), .RX_PEND(rx_pend),
        .RX_ACK(rx_ack),
        .OUT_ADDR(out_addr), .OUT_DATA(out_data), .OUT_LAST(out_last),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .COUNT(count), .OVERFLOW(overflow), .OVF_CLR(ovf_clr),
        .ACK_STATE(ack_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rx_req    = 1'b0;
        rx_pend   = 1'b0;
        rx_addr   = '0;
        rx_data   = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        exp_q     = {};
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // driver: full four-phase transfer of one word; scoreboard records what should be stored
    task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic pend);
        rx_addr = a;
        rx_data = d;
        rx_pend = pend;
        rx_req  = 1'b1;
        tick();
        rx_req = 1'b0;
        tick();
        exp_q.push_back({~pend, a, d});
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rx_ack !== 1'b0 || out_valid !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: ack=%b valid=%b count=%0d ovf=%b required 0 0 0 0",
                     rx_ack, out_valid, count, overflow);
        end
    endtask

    task automatic test_single_word();
        do_reset();
        rx_addr = 8'hAB;
        rx_data = 32'h12345678;
        rx_pend = 1'b0;
        rx_req  = 1'b1;
        tick();
        checks++;
        if (rx_ack !== 1'b1 || out_valid !== 1'b1 || out_last !== 1'b1 || count !== 3'd1 ||
            out_addr !== 8'hAB || out_data !== 32'h12345678) begin
            errors++;
            $display("FAIL single_word: ack=%b valid=%b last=%b count=%0d addr=%h data=%h required 1 1 1 1 ab 12345678",
                     rx_ack, out_valid, out_last, count, out_addr, out_data);
        end
        tick();
        checks++;
        if (rx_ack !== 1'b1 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_word_hold: ack=%b count=%0d required 1 1", rx_ack, count);
        end
        rx_req = 1'b0;
        tick();
        checks++;
        if (rx_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_word_release: ack=%b required 0", rx_ack);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL single_word_read: valid=%b count=%0d required 0 0", out_valid, count);
        end
    endtask

    task automatic test_message();
        logic [EW-1:0] e;
        do_reset();
        send_word(8'h10, 32'hA0000001, 1'b1);
        send_word(8'h11, 32'hA0000002, 1'b1);
        send_word(8'h12, 32'hA0000003, 1'b0);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL message_count: count=%0d required 3", count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {out_last, out_addr, out_data} !== e) begin
                errors++;
                $display("FAIL message_word%0d: valid=%b entry=%h required 1 %h",
                         i, out_valid, {out_last, out_addr, out_data}, e);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

`ifndef ULPB_RXBUF_DROP_EN
    task automatic test_full_stall();
        logic [EW-1:0] e;
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_word(AW'(8'h20 + i), $urandom, 1'($urandom_range(0, 1)));
        rx_addr = 8'h2F;
        rx_data = 32'hCAFEF00D;
        rx_pend = 1'b0;
        rx_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rx_ack !== 1'b0 || count !== 3'd4) begin
                errors++;
                $display("FAIL full_stall%0d: ack=%b count=%0d required 0 4", i, rx_ack, count);
            end
        end
        out_ready = 1'b1;
        void'(exp_q.pop_front());
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (rx_ack === 1'b1) break;
            tick();
        end
        checks++;
        if (rx_ack !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL full_unstall: ack=%b count=%0d required 1 4", rx_ack, count);
        end
        exp_q.push_back({1'b1, 8'h2F, 32'hCAFEF00D});
        rx_req = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {out_last, out_addr, out_data} !== e) begin
                errors++;
                $display("FAIL full_drain%0d: entry=%h required %h", i, {out_last, out_addr, out_data}, e);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask
`else
    task automatic test_drop();
        logic [EW-1:0] e;
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_word(AW'(8'h30 + i), $urandom, 1'b0);
        rx_addr = 8'h3F;
        rx_data = 32'hDEADBEEF;
        rx_pend = 1'b0;
        rx_req  = 1'b1;
        tick();
        checks++;
        if (rx_ack !== 1'b1 || overflow !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL drop: ack=%b ovf=%b count=%0d required 1 1 4", rx_ack, overflow, count);
        end
        rx_req = 1'b0;
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL drop_clear: ovf=%b required 0", overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_q.pop_front();
            checks++;
            if ({out_last, out_addr, out_data} !== e || out_data === 32'hDEADBEEF) begin
                errors++;
                $display("FAIL drop_drain%0d: entry=%h required %h", i, {out_last, out_addr, out_data}, e);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL drop_empty: valid=%b count=%0d required 0 0", out_valid, count);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [EW-1:0] e;
        do_reset();
        send_word(8'h40, $urandom, 1'b1);
        send_word(8'h41, $urandom, 1'b0);
        for (int i = 0; i < 10; i++) begin
            rx_addr   = AW'(8'h50 + i);
            rx_data   = $urandom;
            rx_pend   = 1'($urandom_range(0, 1));
            rx_req    = 1'b1;
            out_ready = 1'b1;
            e = exp_q[0];
            checks++;
            if ({out_last, out_addr, out_data} !== e) begin
                errors++;
                $display("FAIL b2b_head%0d: entry=%h required %h", i, {out_last, out_addr, out_data}, e);
            end
            tick();
            void'(exp_q.pop_front());
            exp_q.push_back({~rx_pend, rx_addr, rx_data});
            checks++;
            if (count !== 3'd2 || rx_ack !== 1'b1) begin
                errors++;
                $display("FAIL b2b_count%0d: count=%0d ack=%b required 2 1", i, count, rx_ack);
            end
            rx_req    = 1'b0;
            out_ready = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(8'h60, $urandom, 1'b1);
        send_word(8'h61, $urandom, 1'b1);
        rx_addr = 8'h62;
        rx_data = 32'h0BADF00D;
        rx_pend = 1'b0;
        rx_req  = 1'b1;
        tick();
        checks++;
        if (rx_ack !== 1'b1 || count !== 3'd3) begin
            errors++;
            $display("FAIL reset_mid_pre: ack=%b count=%0d required 1 3", rx_ack, count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rx_ack !== 1'b0 || out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_async: ack=%b valid=%b count=%0d required 0 0 0", rx_ack, out_valid, count);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if (rx_ack !== 1'b1 || count !== 3'd1 || out_data !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL reset_mid_rereq: ack=%b count=%0d data=%h required 1 1 0badf00d", rx_ack, count, out_data);
        end
        rx_req = 1'b0;
        tick();
    endtask

    // Reference model: an ordered queue of stored words, a flag for "current request already
    // answered" and a sticky overflow bit; the node side follows the four-phase protocol.
    task automatic test_random();
        logic m_ack, m_ovf, take, drop;
        logic [EW-1:0] head;
        do_reset();
        m_ack = 1'b0;
        m_ovf = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++;
            if (rx_ack !== m_ack || out_valid !== (exp_q.size() > 0) ||
                count !== CW'(exp_q.size()) || overflow !== m_ovf) begin
                errors++;
                $display("FAIL random_ctrl cyc%0d: ack=%b valid=%b count=%0d ovf=%b required %b %b %0d %b",
                         cyc, rx_ack, out_valid, count, overflow, m_ack, exp_q.size() > 0, exp_q.size(), m_ovf);
            end
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                checks++;
                if ({out_last, out_addr, out_data} !== head) begin
                    errors++;
                    $display("FAIL random_head cyc%0d: entry=%h required %h", cyc, {out_last, out_addr, out_data}, head);
                end
            end
            if (rx_req && m_ack) begin
                rx_req = 1'b0;
            end else if (!rx_req && !m_ack && $urandom_range(0, 9) < 6) begin
                rx_req  = 1'b1;
                rx_addr = AW'($urandom);
                rx_data = $urandom;
                rx_pend = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 9) < 4);
            ovf_clr   = ($urandom_range(0, 9) == 0);
            take = !m_ack && rx_req && (exp_q.size() < DEPTH);
`ifdef ULPB_RXBUF_DROP_EN
            drop = !m_ack && rx_req && (exp_q.size() == DEPTH);
`else
            drop = 1'b0;
`endif
            if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (take) exp_q.push_back({~rx_pend, rx_addr, rx_data});
            if (drop) m_ovf = 1'b1;
`ifdef ULPB_RXBUF_DROP_EN
            else if (ovf_clr) m_ovf = 1'b0;
`endif
            m_ack = m_ack ? rx_req : (take || drop);
            tick();
        end
        rx_req    = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        rx_req    = 1'b0;
        rx_pend   = 1'b0;
        rx_addr   = '0;
        rx_data   = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_message();
`ifndef ULPB_RXBUF_DROP_EN
        test_full_stall();
`else
        test_drop();
`endif
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
